// File: rtl/vbw_subtractor_pipe.sv
// Two-stage variable bit-width subtractor (1x64/2x32/4x16/8x8 lanes): a - b - bi, low half then high half.
// Optional unsigned saturation of borrowed lanes when VBW_SUB_SAT_EN is defined.
module vbw_subtractor_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bi,
  input  logic [1:0]  control,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        bo,
  output logic [7:0]  lane_borrow
);

  // Low byte-index bits that stay inside one lane: lane start has them all 0, lane MSB all 1.
  function automatic logic [2:0] f_lane_mask(input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return 3'd7;
      2'b01:   return 3'd3;
      2'b10:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  logic        r_s1_valid;
  logic [31:0] r_s_lo;
  logic        r_c32;
  logic [3:0]  r_lb_lo;
  logic [31:0] r_a_hi;
  logic [31:0] r_b_hi;
  logic [1:0]  r_ctrl;

  logic        r_out_valid;
  logic [63:0] r_s;
  logic        r_bo;
  logic [7:0]  r_lb;

  logic        w_s2_ready;
  logic        w_accept;
  logic        w_advance;
  logic [2:0]  w_mask1;
  logic [2:0]  w_mask2;
  logic [31:0] w_s1;
  logic [3:0]  w_lb1;
  logic [31:0] w_s2;
  logic [3:0]  w_lb2;
  logic [63:0] w_s_raw;
  logic [7:0]  w_lb_raw;
  logic [63:0] w_s_out;
  logic        w_bo;

  assign w_mask1    = f_lane_mask(control);
  assign w_mask2    = f_lane_mask(r_ctrl);
  assign w_s2_ready = ~r_out_valid | out_ready;
  assign in_ready   = ~r_s1_valid | w_s2_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_advance  = r_s1_valid & w_s2_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lo
      localparam logic [2:0] BYTE_IDX = 3'(gi);
      logic       w_cin;
      logic       w_co;
      logic [7:0] w_sum;
      if (gi == 0) begin : g_first
        assign w_cin = (control == 2'b00) ? ~bi : 1'b1;
      end else begin : g_rest
        assign w_cin = ((BYTE_IDX & w_mask1) == 3'd0) ? 1'b1 : g_lo[gi-1].w_co;
      end
      assign {w_co, w_sum}     = {1'b0, a[gi*8 +: 8]} + {1'b0, ~b[gi*8 +: 8]} + {8'd0, w_cin};
      assign w_s1[gi*8 +: 8]   = w_sum;
      assign w_lb1[gi]         = ((BYTE_IDX & w_mask1) == w_mask1) & ~w_co;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_hi
      localparam logic [2:0] BYTE_IDX = 3'(gi + 4);
      logic       w_cin;
      logic       w_co;
      logic [7:0] w_sum;
      // Only the 1x64 mode continues a chain into byte 4; every other mode starts a lane there.
      if (gi == 0) begin : g_first
        assign w_cin = ((BYTE_IDX & w_mask2) == 3'd0) ? 1'b1 : r_c32;
      end else begin : g_rest
        assign w_cin = ((BYTE_IDX & w_mask2) == 3'd0) ? 1'b1 : g_hi[gi-1].w_co;
      end
      assign {w_co, w_sum}     = {1'b0, r_a_hi[gi*8 +: 8]} + {1'b0, ~r_b_hi[gi*8 +: 8]} + {8'd0, w_cin};
      assign w_s2[gi*8 +: 8]   = w_sum;
      assign w_lb2[gi]         = ((BYTE_IDX & w_mask2) == w_mask2) & ~w_co;
    end
  endgenerate

  assign w_s_raw  = {w_s2, r_s_lo};
  assign w_lb_raw = {w_lb2, r_lb_lo};
  assign w_bo     = (r_ctrl == 2'b00) & ~g_hi[3].w_co;

`ifdef VBW_SUB_SAT_EN
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sat
      localparam logic [2:0] BYTE_IDX = 3'(gi);
      // The borrow that governs a byte sits at its lane's MSB byte.
      assign w_s_out[gi*8 +: 8] = w_lb_raw[BYTE_IDX | w_mask2] ? 8'd0 : w_s_raw[gi*8 +: 8];
    end
  endgenerate
`else
  assign w_s_out = w_s_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_bo        <= 1'b0;
      r_lb        <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s_lo     <= w_s1;
        r_c32      <= g_lo[3].w_co;
        r_lb_lo    <= w_lb1;
        r_a_hi     <= a[63:32];
        r_b_hi     <= b[63:32];
        r_ctrl     <= control;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s  <= w_s_out;
          r_bo <= w_bo;
          r_lb <= w_lb_raw;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign s           = r_s;
  assign bo          = r_bo;
  assign lane_borrow = r_lb;

endmodule
